// File: rtl/mem_blk_ctrl.sv
// Cache-side initiator for the main-memory block interface: optional dirty
// write-back followed by a block refill, with strobes held for MEM_LAT cycles.
module mem_blk_ctrl #(
    parameter int PA_WIDTH  = 32,
    parameter int BLK_WIDTH = 512,
    parameter int WRD_WIDTH = 32,
    parameter int MEM_LAT   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wb,
    input  logic [PA_WIDTH-1:0]  req_victim_addr,
    input  logic [BLK_WIDTH-1:0] req_victim_data,
    input  logic [PA_WIDTH-1:0]  req_fill_addr,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [BLK_WIDTH-1:0] resp_data,
    output logic                 busy,
    output logic [PA_WIDTH-1:0]  mem_addr,
    output logic                 mem_rd_en,
    output logic                 mem_wr_en,
    output logic [BLK_WIDTH-1:0] mem_wr_data,
    input  logic [BLK_WIDTH-1:0] mem_rd_data
);

    localparam int OFF_BITS = $clog2(BLK_WIDTH / 8);
    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);
    localparam logic [PA_WIDTH-1:0] ALIGN_MASK =
        {{(PA_WIDTH - OFF_BITS){1'b1}}, {OFF_BITS{1'b0}}};

    if ((BLK_WIDTH % WRD_WIDTH) != 0 || MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_param
        $error("mem_blk_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [PA_WIDTH-1:0]    victim_addr_q, victim_addr_d;
    logic [BLK_WIDTH-1:0]   victim_data_q, victim_data_d;
    logic [PA_WIDTH-1:0]    fill_addr_q, fill_addr_d;
    logic [BLK_WIDTH-1:0]   resp_data_q, resp_data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            victim_addr_q <= '0;
            victim_data_q <= '0;
            fill_addr_q   <= '0;
            resp_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            victim_addr_q <= victim_addr_d;
            victim_data_q <= victim_data_d;
            fill_addr_q   <= fill_addr_d;
            resp_data_q   <= resp_data_d;
        end
    end

    // Addresses are aligned once at capture so the strobed address is always clean.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        victim_addr_d = victim_addr_q;
        victim_data_d = victim_data_q;
        fill_addr_d   = fill_addr_q;
        resp_data_d   = resp_data_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    victim_addr_d = req_victim_addr & ALIGN_MASK;
                    victim_data_d = req_victim_data;
                    fill_addr_d   = req_fill_addr & ALIGN_MASK;
                    cnt_d         = '0;
                    state_d       = req_wb ? WB : FILL;
                end
            end
            WB: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = FILL;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            FILL: begin
                if (cnt_q == LAST_CNT) begin
                    resp_data_d = mem_rd_data;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode straight from the state flop so an async reset drops them at once.
    always_comb begin
        req_ready   = (state_q == IDLE);
        busy        = (state_q != IDLE);
        resp_valid  = (state_q == RESP);
        resp_data   = resp_data_q;
        mem_wr_en   = (state_q == WB);
        mem_rd_en   = (state_q == FILL);
        mem_addr    = '0;
        mem_wr_data = '0;
        if (state_q == WB) begin
            mem_addr    = victim_addr_q;
            mem_wr_data = victim_data_q;
        end else if (state_q == FILL) begin
            mem_addr = fill_addr_q;
        end
    end

endmodule

// File: tb/tb_mem_blk_ctrl.sv
// Scoreboard bench for mem_blk_ctrl: directed misses against a small block memory
// model, plus a second instance built with MEM_LAT=1.
module tb_mem_blk_ctrl;

    localparam int PA = 32;
    localparam int BW = 512;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid, req_ready, req_wb;
    logic [PA-1:0] req_victim_addr, req_fill_addr;
    logic [BW-1:0] req_victim_data;
    logic          resp_valid, resp_ready, busy;
    logic [BW-1:0] resp_data;
    logic [PA-1:0] mem_addr;
    logic          mem_rd_en, mem_wr_en;
    logic [BW-1:0] mem_wr_data, mem_rd_data;

    logic          req_valid_1, req_ready_1, req_wb_1;
    logic [PA-1:0] req_victim_addr_1, req_fill_addr_1;
    logic [BW-1:0] req_victim_data_1;
    logic          resp_valid_1, resp_ready_1, busy_1;
    logic [BW-1:0] resp_data_1;
    logic [PA-1:0] mem_addr_1;
    logic          mem_rd_en_1, mem_wr_en_1;
    logic [BW-1:0] mem_wr_data_1, mem_rd_data_1;

    int n_vec = 0;
    int n_miss = 0;
    logic [BW-1:0] exp_q[$];

    mem_blk_ctrl #(.PA_WIDTH(PA), .BLK_WIDTH(BW), .WRD_WIDTH(32), .MEM_LAT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wb(req_wb),
        .req_victim_addr(req_victim_addr), .req_victim_data(req_victim_data),
        .req_fill_addr(req_fill_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .busy(busy), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    mem_blk_ctrl #(.PA_WIDTH(PA), .BLK_WIDTH(BW), .WRD_WIDTH(32), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_1), .req_ready(req_ready_1), .req_wb(req_wb_1),
        .req_victim_addr(req_victim_addr_1), .req_victim_data(req_victim_data_1),
        .req_fill_addr(req_fill_addr_1),
        .resp_valid(resp_valid_1), .resp_ready(resp_ready_1), .resp_data(resp_data_1),
        .busy(busy_1), .mem_addr(mem_addr_1), .mem_rd_en(mem_rd_en_1), .mem_wr_en(mem_wr_en_1),
        .mem_wr_data(mem_wr_data_1), .mem_rd_data(mem_rd_data_1)
    );

    // Block i of the model holds bytes 0x10+i until written; index is addr[9:6].
    logic [BW-1:0] store [16];
    logic [15:0]   written = '0;
    logic [3:0]    mem_idx;
    assign mem_idx       = mem_addr[9:6];
    assign mem_rd_data   = written[mem_idx] ? store[mem_idx] : {64{8'h10 + {4'h0, mem_idx}}};
    assign mem_rd_data_1 = {64{8'h5A}};

    always @(posedge clk) begin
        if (mem_wr_en) begin
            store[mem_idx]   <= mem_wr_data;
            written[mem_idx] <= 1'b1;
        end
    end

    // Monitor: one pop per response handshake.
    always @(negedge clk) begin
        logic [BW-1:0] exp;
        if (resp_valid && resp_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("[TB] FAIL resp_scoreboard: got unexpected response %h", resp_data);
            end else begin
                exp = exp_q.pop_front();
                if (resp_data !== exp) begin
                    n_miss++;
                    $display("[TB] FAIL resp_data: got %h, expected %h", resp_data, exp);
                end
            end
        end
    end

    always @(negedge clk) begin
        n_vec++;
        if ((mem_rd_en && mem_wr_en) || (mem_rd_en_1 && mem_wr_en_1)) begin
            n_miss++;
            $display("[TB] FAIL strobe_overlap: got rd=%0b wr=%0b rd1=%0b wr1=%0b, expected no overlap",
                     mem_rd_en, mem_wr_en, mem_rd_en_1, mem_wr_en_1);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic wb, input logic [PA-1:0] va, input logic [BW-1:0] vd,
                                 input logic [PA-1:0] fa, input logic push, input logic [BW-1:0] exp);
        req_wb          = wb;
        req_victim_addr = va;
        req_victim_data = vd;
        req_fill_addr   = fa;
        req_valid       = 1'b1;
        if (push) exp_q.push_back(exp);
        @(posedge clk); #1;
        req_valid       = 1'b0;
        req_wb          = ~wb;
        req_victim_addr = 32'hFFFF_FFC0;
        req_victim_data = {16{32'h0BAD_0BAD}};
        req_fill_addr   = 32'h0000_03C0;
        checkOutput("accept_busy", BW'(busy), BW'(1'b1));
    endtask

    // Called one step after the accept edge; returns one step after resp_valid rises.
    task automatic checkXfer(input logic wb, input logic [PA-1:0] va, input logic [BW-1:0] vd,
                             input logic [PA-1:0] fa);
        if (wb) begin
            for (int k = 0; k < 4; k++) begin
                checkOutput("wb_wr_en", BW'(mem_wr_en), BW'(1'b1));
                checkOutput("wb_rd_en", BW'(mem_rd_en), BW'(1'b0));
                checkOutput("wb_addr", BW'(mem_addr), BW'(va));
                checkOutput("wb_data", mem_wr_data, vd);
                checkOutput("wb_req_ready", BW'(req_ready), BW'(1'b0));
                @(posedge clk); #1;
            end
        end
        for (int k = 0; k < 4; k++) begin
            checkOutput("fill_rd_en", BW'(mem_rd_en), BW'(1'b1));
            checkOutput("fill_wr_en", BW'(mem_wr_en), BW'(1'b0));
            checkOutput("fill_addr", BW'(mem_addr), BW'(fa));
            checkOutput("fill_resp_valid", BW'(resp_valid), BW'(1'b0));
            @(posedge clk); #1;
        end
        checkOutput("resp_valid", BW'(resp_valid), BW'(1'b1));
        checkOutput("resp_rd_en", BW'(mem_rd_en), BW'(1'b0));
        checkOutput("resp_busy", BW'(busy), BW'(1'b1));
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checkOutput("idle_resp_valid", BW'(resp_valid), BW'(1'b0));
        checkOutput("idle_req_ready", BW'(req_ready), BW'(1'b1));
    endtask

    initial begin
        req_valid = 0; req_wb = 0; req_victim_addr = '0; req_victim_data = '0; req_fill_addr = '0;
        resp_ready = 0;
        req_valid_1 = 0; req_wb_1 = 0; req_victim_addr_1 = '0; req_victim_data_1 = '0;
        req_fill_addr_1 = '0; resp_ready_1 = 0;

        #12;
        checkOutput("rst_req_ready", BW'(req_ready), BW'(1'b1));
        checkOutput("rst_busy", BW'(busy), BW'(1'b0));
        checkOutput("rst_strobes", BW'({mem_rd_en, mem_wr_en, resp_valid}), BW'(3'b000));
        checkOutput("rst_mem_addr", BW'(mem_addr), BW'(32'h0));
        checkOutput("rst_resp_data", resp_data, '0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] clean miss to 0x47");
        applyStimulus(1'b0, 32'h0, '0, 32'h0000_0047, 1'b1, {64{8'h11}});
        checkXfer(1'b0, 32'h0, '0, 32'h40);
        handshake();

        $display("[TB] dirty miss victim 0x80 fill 0x40");
        applyStimulus(1'b1, 32'h80, {64{8'hA5}}, 32'h40, 1'b1, {64{8'h11}});
        checkXfer(1'b1, 32'h80, {64{8'hA5}}, 32'h40);
        handshake();
        applyStimulus(1'b0, 32'h0, '0, 32'h80, 1'b1, {64{8'hA5}});
        checkXfer(1'b0, 32'h0, '0, 32'h80);
        handshake();

        $display("[TB] back-pressure with req_valid held high");
        applyStimulus(1'b0, 32'h0, '0, 32'hC0, 1'b1, {64{8'h13}});
        req_wb = 1'b0; req_fill_addr = 32'h100; req_valid = 1'b1;
        exp_q.push_back({64{8'h14}});
        resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checkOutput("bp_req_ready", BW'(req_ready), BW'(1'b0));
            checkOutput("bp_busy", BW'(busy), BW'(1'b1));
            @(posedge clk); #1;
        end
        checkOutput("bp_resp_valid", BW'(resp_valid), BW'(1'b1));
        @(posedge clk); #1;
        checkOutput("bp_idle_ready", BW'(req_ready), BW'(1'b1));
        checkOutput("bp_idle_busy", BW'(busy), BW'(1'b0));
        @(posedge clk); #1;
        req_valid = 1'b0;
        checkOutput("bp_second_busy", BW'(busy), BW'(1'b1));
        for (int k = 0; k < 4; k++) begin
            checkOutput("bp_second_rd_en", BW'(mem_rd_en), BW'(1'b1));
            checkOutput("bp_second_addr", BW'(mem_addr), BW'(32'h100));
            @(posedge clk); #1;
        end
        checkOutput("bp_second_resp", BW'(resp_valid), BW'(1'b1));
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checkOutput("bp_second_idle", BW'(req_ready), BW'(1'b1));

        $display("[TB] response stall");
        applyStimulus(1'b0, 32'h0, '0, 32'h140, 1'b1, {64{8'h15}});
        checkXfer(1'b0, 32'h0, '0, 32'h140);
        for (int k = 0; k < 5; k++) begin
            checkOutput("stall_resp_valid", BW'(resp_valid), BW'(1'b1));
            checkOutput("stall_resp_data", resp_data, {64{8'h15}});
            @(posedge clk); #1;
        end
        handshake();

        $display("[TB] reset in second write-back cycle");
        applyStimulus(1'b1, 32'h180, {16{32'hDEAD_BEEF}}, 32'h1C0, 1'b0, '0);
        @(posedge clk); #1;
        checkOutput("rstwb_wr_en_before", BW'(mem_wr_en), BW'(1'b1));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstwb_wr_en", BW'(mem_wr_en), BW'(1'b0));
        checkOutput("rstwb_busy", BW'(busy), BW'(1'b0));
        checkOutput("rstwb_req_ready", BW'(req_ready), BW'(1'b1));
        checkOutput("rstwb_mem_addr", BW'(mem_addr), BW'(32'h0));
        checkOutput("rstwb_wr_data", mem_wr_data, '0);
        checkOutput("rstwb_resp_data", resp_data, '0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(1'b0, 32'h0, '0, 32'h1C0, 1'b1, {64{8'h17}});
        checkXfer(1'b0, 32'h0, '0, 32'h1C0);
        handshake();

        $display("[TB] MEM_LAT=1 dirty miss");
        req_wb_1 = 1'b1; req_victim_addr_1 = 32'hC5; req_victim_data_1 = {16{32'hCAFE_F00D}};
        req_fill_addr_1 = 32'h100; req_valid_1 = 1'b1;
        @(posedge clk); #1;
        req_valid_1 = 1'b0;
        checkOutput("lat1_wr_en", BW'(mem_wr_en_1), BW'(1'b1));
        checkOutput("lat1_wr_addr", BW'(mem_addr_1), BW'(32'hC0));
        checkOutput("lat1_wr_data", mem_wr_data_1, {16{32'hCAFE_F00D}});
        @(posedge clk); #1;
        checkOutput("lat1_rd_en", BW'({mem_rd_en_1, mem_wr_en_1}), BW'(2'b10));
        checkOutput("lat1_rd_addr", BW'(mem_addr_1), BW'(32'h100));
        checkOutput("lat1_early_resp", BW'(resp_valid_1), BW'(1'b0));
        @(posedge clk); #1;
        checkOutput("lat1_resp_valid", BW'(resp_valid_1), BW'(1'b1));
        checkOutput("lat1_resp_data", resp_data_1, {64{8'h5A}});
        checkOutput("lat1_busy", BW'(busy_1), BW'(1'b1));
        resp_ready_1 = 1'b1;
        @(posedge clk); #1;
        resp_ready_1 = 1'b0;
        checkOutput("lat1_idle", BW'({req_ready_1, resp_valid_1}), BW'(2'b10));

        checkOutput("scoreboard_empty", BW'(exp_q.size()), BW'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
